// File: rtl/gpr_exec_pkg.sv
// Shared opcodes, sequencer state encoding and multiplier length for the
// gpr execute/write-back block.
package gpr_exec_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    localparam int MUL_CYCLES = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_e;

endpackage

// File: rtl/gpr_mul_seq.sv
// Iterative shift-add multiplier: one partial product per cycle for
// MUL_CYCLES cycles, keeping only the low WIDTH bits of the product.
module gpr_mul_seq
    import gpr_exec_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] product_o
);

    localparam int CW = $clog2(MUL_CYCLES);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;

    always_comb begin
        acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else if (start_i) begin
            acc_q    <= '0;
            mcand_q  <= a_i;
            mplier_q <= b_i;
            cnt_q    <= CW'(MUL_CYCLES - 1);
            busy_q   <= 1'b1;
        end else if (busy_q) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q - 1'b1;
            if (cnt_q == '0) begin
                busy_q <= 1'b0;
            end
        end
    end

    // The final product is presented during the last iteration so the
    // caller can register it on the same edge that retires the multiply.
    assign busy_o    = busy_q;
    assign valid_o   = busy_q && (cnt_q == '0);
    assign product_o = acc_d;

endmodule

// File: rtl/gpr_exec_wb.sv
// Serial execute/write-back sequencer around the gpr register file:
// accept, read operands, execute (ALU or iterative MUL), write back.
module gpr_exec_wb
    import gpr_exec_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [AW-1:0]    in_ra,
    input  logic [AW-1:0]    in_rb,
    input  logic [AW-1:0]    in_rc,
    output logic [AW-1:0]    Sa,
    output logic [AW-1:0]    Sb,
    input  logic [WIDTH-1:0] Souta,
    input  logic [WIDTH-1:0] Soutb,
    output logic             Sw,
    output logic [AW-1:0]    Sc,
    output logic [WIDTH-1:0] Sin,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    logic [2:0]       op_q;
    logic [AW-1:0]    rc_q, sa_q, sb_q, sc_q;
    logic [WIDTH-1:0] opa_q, opb_q, sin_q;
    logic [WIDTH-1:0] alu_res;
    logic             accept, exec_done;
    logic             mul_start, mul_busy, mul_valid;
    logic [WIDTH-1:0] mul_prod;

    // Operands are fed straight from the read port so the multiplier's
    // first iteration lands in the first EXEC cycle.
    assign mul_start = (state_q == READ) && (op_q == OP_MUL);

    gpr_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (mul_start),
        .a_i       (Souta),
        .b_i       (Soutb),
        .busy_o    (mul_busy),
        .valid_o   (mul_valid),
        .product_o (mul_prod)
    );

    assign in_ready  = (state_q == IDLE) && !mul_busy;
    assign accept    = in_valid && in_ready;
    assign exec_done = (op_q != OP_MUL) || mul_valid;

    always_comb begin
        alu_res = '0;
        case (op_q)
            OP_ADD:  alu_res = opa_q + opb_q;
            OP_SUB:  alu_res = opa_q - opb_q;
            OP_AND:  alu_res = opa_q & opb_q;
            OP_OR:   alu_res = opa_q | opb_q;
            OP_XOR:  alu_res = opa_q ^ opb_q;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(opa_q) < $signed(opb_q))};
            OP_SLL:  alu_res = opa_q << opb_q[4:0];
            default: alu_res = mul_prod;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = READ;
            READ:    state_d = EXEC;
            EXEC:    if (exec_done) state_d = WB;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= OP_ADD;
            rc_q    <= '0;
            sa_q    <= '0;
            sb_q    <= '0;
            sc_q    <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            sin_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q <= in_op;
                rc_q <= in_rc;
                sa_q <= in_ra;
                sb_q <= in_rb;
            end
            if (state_q == READ) begin
                opa_q <= Souta;
                opb_q <= Soutb;
            end
            if (state_q == EXEC && exec_done) begin
                sc_q  <= rc_q;
                sin_q <= alu_res;
            end
        end
    end

    assign Sa   = sa_q;
    assign Sb   = sb_q;
    assign Sc   = sc_q;
    assign Sin  = sin_q;
    assign Sw   = (state_q == WB);
    assign done = (state_q == WB);
    assign busy = (state_q != IDLE);

endmodule

// File: doc/gpr_exec_wb.md
Name: gpr_exec_wb

Overview:
- Serial execute/write-back sequencer that sits around the gpr register file.
- Accepts one register-register instruction at a time over a valid/ready handshake and drives gpr read addresses Sa/Sb.
- Captures Souta/Soutb, computes the result (single-cycle ALU or 32-cycle iterative multiply), then writes the result back through Sw/Sc/Sin.

Parameters:
- WIDTH, 32, data width (matches gpr Sin/Souta/Soutb).
- AW, 5, register address width (matches gpr Sa/Sb/Sc).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  instruction offered.
- in_ready  out  1  block can accept; high only in IDLE.
- in_op  in  3  opcode.
- in_ra  in  AW  source A register.
- in_rb  in  AW  source B register.
- in_rc  in  AW  destination register.
- Sa  out  AW  gpr read address A (registered).
- Sb  out  AW  gpr read address B (registered).
- Souta  in  WIDTH  gpr read data A (combinational read of Sa).
- Soutb  in  WIDTH  gpr read data B.
- Sw  out  1  gpr write enable, one-cycle pulse.
- Sc  out  AW  gpr write address.
- Sin  out  WIDTH  gpr write data.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse, coincident with Sw.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; Sa=Sb=Sc=0, Sin=0, Sw=0, done=0, busy=0; in_ready=1 once reset is applied. Reset mid-instruction abandons it; no write occurs.
- Opcodes:
  - 000 ADD, 001 SUB (A-B), 010 AND, 011 OR, 100 XOR.
  - 101 SLT: signed A<B gives 1, else 0.
  - 110 SLL: A << B[4:0].
  - 111 MUL: low WIDTH bits of A*B.
  - All arithmetic is modulo 2^WIDTH; overflow is ignored.
- FSM states: IDLE, READ, EXEC, WB.
  - IDLE: in_ready=1. When in_valid=1, accept: latch op/rc, load Sa<=in_ra, Sb<=in_rb, go to READ.
  - READ (1 cycle): Sa/Sb are stable; capture Souta/Soutb into operand regs at the end of the cycle. Go to EXEC.
  - EXEC: non-MUL ops take 1 cycle; the result is registered, then go to WB. MUL runs a shift-add multiplier for exactly 32 cycles (counter 31 down to 0), then goes to WB.
  - WB (1 cycle): Sw=1, done=1, Sc=rc, Sin=result; the gpr writes on the edge ending WB. Then go to IDLE.
- Latency: for an accept edge at T, Sw is high during cycle T+3 for ALU ops and T+34 for MUL. The next accept is possible in the cycle after WB.
- Outside WB: Sw=0 and done=0. Sc and Sin hold their last values.
- in_op/in_ra/in_rb/in_rc are sampled only at acceptance; later changes are ignored.
- in_valid is ignored while busy. No queuing.
- Destination r0 is written like any other register; the block applies no special case.
- Read-after-write: the write completes before the next READ, so no forwarding is required.

Decomposition:
- Package gpr_exec_pkg: opcode localparams (OP_ADD..OP_MUL), FSM state encoding, MUL_CYCLES=32.
- Sub-module gpr_mul_seq: iterative shift-add multiplier.
  - Inputs: start, a, b.
  - Outputs: busy, valid, product low WIDTH bits.
  - Instantiated once; the EXEC state waits on its valid.

Test Plan:
- Reset: assert rst_n=0 mid-cycle -> Sw=0, busy=0, in_ready=1, Sa=Sb=Sc=0 immediately (asynchronous).
- ADD: preload r5=AAAA5555, r10=12345678; issue op=000, ra=5, rb=10, rc=1 -> Sw=1, Sc=1, Sin=BCDEABCD at accept+3; done pulses one cycle.
- SUB and SLT: SUB ra=10, rb=5 -> Sin=678A0123; SLT ra=5, rb=10 -> Sin=00000001 (signed); SLT ra=10, rb=5 -> Sin=00000000.
- MUL: r2=FFFFFFFF, r3=00000003, op=111 -> Sin=FFFFFFFD, Sw at accept+34; in_ready=0 throughout.
- Back-to-back: keep in_valid high with ADD r1<-r5+r10, then ADD r4<-r1+r1 -> second Sin=79BD579A; second accept occurs the cycle after the first WB.
- Reset mid-MUL: drop rst_n at EXEC cycle 10 -> no Sw pulse; target register keeps its old value; block returns to IDLE.
